fire_event_confirm: RTL
=======================

// Module: fire_event_confirm
// PURPOSE
//  Downstream of the fire comparator: consumes its 1-bit majority Output (EventIn) and 3-bit sensor Flag (FlagIn).
//  Debounces EventIn over sampled ticks, confirms and latches a fire alarm, and emits one valid/ready event record per confirmation.
//  Holds the alarm until the input is quiet for CLEAR_CNT samples AND an operator Ack has been seen.
// PARAMETERS
//  CONFIRM_CNT  4  consecutive sampled EventIn=1 needed to confirm (>=1)
//  CLEAR_CNT    8  consecutive sampled EventIn=0 needed before clear (>=1)
//  CNT_W        8  width of EvtCount (FIRE_EVT_COUNT_EN only)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous reset, active low
//  SampleEn  in   1      sample strobe; EventIn/FlagIn evaluated only when 1
//  EventIn   in   1      comparator Output
//  FlagIn    in   3      comparator Flag (sensor participation)
//  Ack       in   1      operator acknowledge pulse
//  EvtReady  in   1      consumer ready for event record
//  Alarm     out  1      confirmed alarm, registered
//  Warning   out  1      last sampled FlagIn!=0 while Alarm=0
//  EvtValid  out  1      event record valid
//  EvtFlags  out  3      FlagIn snapshot at the confirming sample
//  Overrun   out  1      sticky: confirmation while EvtValid still pending
//  State     out  2      FSM state: 0 IDLE, 1 SUSPECT, 2 ALARM, 3 CLEARING
//  EvtCount  out  CNT_W  confirmations so far (FIRE_EVT_COUNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): State=IDLE; all outputs and run/quiet counters 0; AckSeen=0.
//  - Counters sized $clog2(max(CONFIRM_CNT,CLEAR_CNT))+1 bits; quiet saturates at CLEAR_CNT.
//  - IDLE: sample EventIn=1 -> SUSPECT, run=1; if CONFIRM_CNT==1, go straight to ALARM (confirm).
//  - SUSPECT: sample EventIn=1 -> run+1; at run==CONFIRM_CNT -> ALARM (confirm). Sample EventIn=0 -> IDLE, run=0.
//  - Confirm edge: Alarm<=1; EvtFlags<=FlagIn; EvtValid<=1.
//    All visible after the edge taking the CONFIRM_CNT-th sample, so latency = 0 cycles past that edge.
//  - Confirm with EvtValid still 1: EvtFlags overwritten, EvtValid stays 1, Overrun<=1. Overrun clears on reset only.
//  - Handshake: EvtValid/EvtFlags stable while EvtValid=1 and EvtReady=0; EvtValid falls on the edge after EvtValid&EvtReady.
//    EvtReady ignored while EvtValid=0.
//  - ALARM: sample EventIn=0 -> CLEARING, quiet=1 (if CLEAR_CNT==1 quiet already satisfied).
//  - CLEARING: sample EventIn=1 -> ALARM, quiet=0, no new record.
//    Sample EventIn=0 -> quiet+1, saturating.
//  - Exit to IDLE, independent of SampleEn: quiet==CLEAR_CNT and (AckSeen or Ack) -> IDLE next edge.
//    On that edge: Alarm<=0, AckSeen<=0, run<=0.
//  - Ack: Ack=1 in ALARM/CLEARING sets sticky AckSeen; Ack in IDLE/SUSPECT ignored.
//    Ack in ALARM does not clear Alarm while EventIn persists.
//  - Warning: registered on SampleEn edges as (FlagIn!=0); forced 0 while Alarm=1.
//  - Alarm stays 1 throughout ALARM and CLEARING; pending EvtValid is unaffected by the IDLE exit.
//  - SampleEn=0: no counter or state change except the Ack exit and the handshake.
// CONFIGURATION
//  FIRE_EVT_COUNT_EN defined: EvtCount port exists; increments on every confirm edge; saturates at all-ones; reset 0.
//  FIRE_EVT_COUNT_EN undefined: EvtCount port and counter absent; all other behaviour identical.
// TESTING
//  1. Defaults, FlagIn=3'b011, EventIn=1 for 4 samples -> after 4th sample edge: Alarm=1, EvtValid=1, EvtFlags=011, State=2.
//  2. EventIn samples 1,1,1,0,1 -> Alarm stays 0; State IDLE after the 0, then SUSPECT; Warning=1 while FlagIn!=0.
//  3. Confirm with EvtReady=0 for 5 clks -> EvtValid/EvtFlags stable.
//     EvtReady=1 -> EvtValid=0 next edge.
//     Re-confirm while pending -> Overrun=1.
//  4. In ALARM, EventIn=0 for 8 samples, no Ack -> State=3, Alarm=1 held.
//     Ack pulse -> State=0, Alarm=0 next edge.
//     Separate run: EventIn=1 at quiet=5 -> State=2, no new EvtValid.
//  5. rst_n low asynchronously mid-SUSPECT and mid-ALARM -> all outputs 0 immediately, before the next clk edge.
//     After release: 4 samples required to confirm again.
//  6. FIRE_EVT_COUNT_EN, CNT_W=2: 5 confirm/clear cycles -> EvtCount 1,2,3,3,3.
//     Without the macro: build succeeds, no EvtCount port.

Source files
------------

// File: rtl/fire_event_confirm.sv
// rtl/fire_event_confirm.sv - debounce fire events, latch the alarm, emit one event record per confirmation
// Optional feature macro: FIRE_EVT_COUNT_EN adds the EvtCount confirmation counter and port.
module fire_event_confirm #(
  parameter int CONFIRM_CNT = 4,
  parameter int CLEAR_CNT   = 8
`ifdef FIRE_EVT_COUNT_EN
  , parameter int CNT_W     = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SampleEn,
  input  logic             EventIn,
  input  logic [2:0]       FlagIn,
  input  logic             Ack,
  input  logic             EvtReady,
  output logic             Alarm,
  output logic             Warning,
  output logic             EvtValid,
  output logic [2:0]       EvtFlags,
  output logic             Overrun,
  output logic [1:0]       State
`ifdef FIRE_EVT_COUNT_EN
  , output logic [CNT_W-1:0] EvtCount
`endif
);

  localparam int MAX_CNT = (CONFIRM_CNT > CLEAR_CNT) ? CONFIRM_CNT : CLEAR_CNT;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] CONFIRM_V = CW'(CONFIRM_CNT);
  localparam logic [CW-1:0] CLEAR_V   = CW'(CLEAR_CNT);
  localparam logic [CW-1:0] ONE_V     = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SUSPECT  = 2'd1,
    S_ALARM    = 2'd2,
    S_CLEARING = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] quiet_q, quiet_d;
  logic          ack_seen_q, ack_seen_d;
  logic          alarm_q, alarm_d;
  logic          warning_q, warning_d;
  logic          evt_valid_q, evt_valid_d;
  logic [2:0]    evt_flags_q, evt_flags_d;
  logic          overrun_q, overrun_d;
  logic          confirm;
  logic          exit_clr;
`ifdef FIRE_EVT_COUNT_EN
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
`endif

  // Next-state: debounce FSM, alarm latch, warning, and event record handshake
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    quiet_d     = quiet_q;
    ack_seen_d  = ack_seen_q;
    alarm_d     = alarm_q;
    evt_valid_d = evt_valid_q;
    evt_flags_d = evt_flags_q;
    overrun_d   = overrun_q;
    confirm     = 1'b0;
    // Clearing exit only needs the quiet window plus an ack; it ignores the sample strobe.
    exit_clr    = (state_q == S_CLEARING) && (quiet_q == CLEAR_V) && (ack_seen_q || Ack);

    case (state_q)
      S_IDLE: begin
        if (SampleEn && EventIn) begin
          run_d = ONE_V;
          if (CONFIRM_V == ONE_V) begin
            state_d = S_ALARM;
            confirm = 1'b1;
          end else begin
            state_d = S_SUSPECT;
          end
        end
      end
      S_SUSPECT: begin
        if (SampleEn) begin
          if (EventIn) begin
            run_d = run_q + ONE_V;
            if (run_q + ONE_V == CONFIRM_V) begin
              state_d = S_ALARM;
              confirm = 1'b1;
            end
          end else begin
            run_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_ALARM: begin
        if (SampleEn && !EventIn) begin
          state_d = S_CLEARING;
          quiet_d = ONE_V;
        end
      end
      S_CLEARING: begin
        if (exit_clr) begin
          state_d = S_IDLE;
          run_d   = '0;
          quiet_d = '0;
        end else if (SampleEn) begin
          if (EventIn) begin
            state_d = S_ALARM;
            quiet_d = '0;
          end else if (quiet_q != CLEAR_V) begin
            quiet_d = quiet_q + ONE_V;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (exit_clr) begin
      ack_seen_d = 1'b0;
    end else if (Ack && (state_q == S_ALARM || state_q == S_CLEARING)) begin
      ack_seen_d = 1'b1;
    end

    if (confirm) alarm_d = 1'b1;
    if (exit_clr) alarm_d = 1'b0;

    warning_d = SampleEn ? (FlagIn != 3'b000) : warning_q;
    if (alarm_d) warning_d = 1'b0;

    // A confirm that lands while the old record is still unaccepted overwrites it.
    if (confirm) begin
      if (evt_valid_q && !EvtReady) overrun_d = 1'b1;
      evt_valid_d = 1'b1;
      evt_flags_d = FlagIn;
    end else if (evt_valid_q && EvtReady) begin
      evt_valid_d = 1'b0;
    end

`ifdef FIRE_EVT_COUNT_EN
    evt_count_d = evt_count_q;
    if (confirm && (evt_count_q != {CNT_W{1'b1}})) evt_count_d = evt_count_q + 1'b1;
`endif
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_q       <= '0;
      quiet_q     <= '0;
      ack_seen_q  <= 1'b0;
      alarm_q     <= 1'b0;
      warning_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_flags_q <= 3'b000;
      overrun_q   <= 1'b0;
`ifdef FIRE_EVT_COUNT_EN
      evt_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      quiet_q     <= quiet_d;
      ack_seen_q  <= ack_seen_d;
      alarm_q     <= alarm_d;
      warning_q   <= warning_d;
      evt_valid_q <= evt_valid_d;
      evt_flags_q <= evt_flags_d;
      overrun_q   <= overrun_d;
`ifdef FIRE_EVT_COUNT_EN
      evt_count_q <= evt_count_d;
`endif
    end
  end

  assign Alarm    = alarm_q;
  assign Warning  = warning_q;
  assign EvtValid = evt_valid_q;
  assign EvtFlags = evt_flags_q;
  assign Overrun  = overrun_q;
  assign State    = state_q;
`ifdef FIRE_EVT_COUNT_EN
  assign EvtCount = evt_count_q;
`endif

endmodule
